irq_ctrl: RTL

// Interrupt controller sitting directly downstream of the timer, UART and other peripherals.
// - Inputs: their interrupt request lines, e.g. the timer's shot flag.
// - Registers: latches requests into pending bits, applies a per-source mask and edge/level mode.
// - Output: the registered active-low IRQ line to the 6502 core.
// - Bus: CPU-visible on the same 4-register peripheral bus as the timer (addr/dbw/dbr/we).

---
 rtl/irq_pkg.sv | 33 +++
 rtl/irq_sync_edge.sv | 35 +++
 rtl/irq_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   - irq_addr_e : register map of the 4-register peripheral bus
//   - STAT_*     : bit positions inside the STAT register
//   - NSRC_MAX   : upper bound on the number of interrupt sources
//   - lowest_set : fixed-priority encoder (bit 0 wins)
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_PEND = 2'd0,
    IRQ_MASK = 2'd1,
    IRQ_MODE = 2'd2,
    IRQ_STAT = 2'd3
  } irq_addr_e;

  localparam int unsigned STAT_ACT     = 7;
  localparam int unsigned STAT_IDX_LSB = 0;
  localparam int unsigned STAT_IDX_W   = 3;
  localparam int unsigned NSRC_MAX     = 8;

  // Index of the lowest-numbered set bit, 0 when the vector is empty.
  function automatic logic [STAT_IDX_W-1:0] lowest_set(input logic [NSRC_MAX-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NSRC_MAX; i++) begin
      if (v[i] && !found) begin
        lowest_set = STAT_IDX_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-source input conditioning.
//   clk, rst_n : system clock, asynchronous active-low reset
//   src        : raw request, may be asynchronous to clk
//   level      : src after SYNC_STAGES synchronizer flops
//   pulse      : one-cycle rising-edge indication of level
module irq_sync_edge
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain   <= '0;
      level_d <= 1'b0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], src};
      level_d <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  // Chain resets to 0, so a source already high at reset release yields one edge.
  assign pulse = level & ~level_d;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller between the peripherals and the 6502 core.
//   clk, rst_n : system clock, asynchronous active-low reset
//   addr, dbw  : register select / write data (0 PEND, 1 MASK, 2 MODE, 3 STAT)
//   we         : write strobe, register written on posedge clk
//   dbr        : combinational read data, no read side effects
//   src        : raw interrupt requests (NSRC of them, 0 = highest priority)
//   irq_n      : registered active-low interrupt to the CPU
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      addr,
  input  logic [7:0]      dbw,
  input  logic            we,
  output logic [7:0]      dbr,
  input  logic [NSRC-1:0] src,
  output logic            irq_n
);

  // Registers are kept at full bus width; bits >= NSRC are forced to 0 so
  // they read back 0 and ignore writes without separate padding in the mux.
  localparam logic [NSRC_MAX-1:0] VALID = NSRC_MAX'((1 << NSRC) - 1);

  logic [NSRC-1:0]     s_src, rise_src;
  logic [NSRC_MAX-1:0] s, rise;
  logic [NSRC_MAX-1:0] pend, mask, mode;
  logic [NSRC_MAX-1:0] pend_next, w1c, active;
  logic [7:0]          stat;
  irq_addr_e           sel;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .src  (src[i]),
      .level(s_src[i]),
      .pulse(rise_src[i])
    );
  end

  assign s    = NSRC_MAX'(s_src);
  assign rise = NSRC_MAX'(rise_src);
  assign sel  = irq_addr_e'(addr);
  assign w1c  = (we && sel == IRQ_PEND) ? (dbw & VALID) : '0;

  // Edge bits: a new edge outranks a same-cycle clear. Level bits track s.
  always_comb begin
    pend_next = '0;
    pend_next = ((mode & (rise | (pend & ~w1c))) | (~mode & s)) & VALID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      irq_n <= 1'b1;
    end else begin
      pend  <= pend_next;
      if (we && sel == IRQ_MASK) mask <= dbw & VALID;
      if (we && sel == IRQ_MODE) mode <= dbw & VALID;
      irq_n <= ~|(pend & mask);
    end
  end

  assign active = pend & mask;

  always_comb begin
    stat = '0;
    stat[STAT_ACT] = |active;
    stat[STAT_IDX_LSB +: STAT_IDX_W] = lowest_set(active);
  end

  always_comb begin
    dbr = '0;
    unique case (sel)
      IRQ_PEND: dbr = pend;
      IRQ_MASK: dbr = mask;
      IRQ_MODE: dbr = mode;
      IRQ_STAT: dbr = stat;
      default:  dbr = '0;
    endcase
  end

endmodule
